alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have in_valid input 1: upstream request valid.
REQ-003 SHALL have in_ready output 1: block can accept a request.
REQ-004 SHALL have alu_op input 2: class, where 00=load/store, 01=branch, 10=R-type, 11=I-type.
REQ-005 SHALL have funct3 input 3 and funct7_5 input 1: instruction function fields.
REQ-006 SHALL have opnd_a input 32 and opnd_b input 32: operands, with the immediate already muxed upstream.
REQ-007 SHALL have alu_inp1 output 32, alu_inp2 output 32 and alu_control output 3: drive to the combinational ALU.
REQ-008 SHALL have alu_out input 32 and alu_zero input 1: ALU response.
REQ-009 SHALL have out_valid output 1 and out_ready input 1: result handshake.
REQ-010 SHALL have out_result output 32, out_zero output 1 and out_illegal output 1: result payload.

Function
REQ-011 SHALL use ALU control encodings ADD=000, SUB=001, AND=010, OR=011, SLT=101.
REQ-012 SHALL decode alu_op 00 to ADD and alu_op 01 to SUB, ignoring funct fields.
REQ-013 SHALL decode alu_op 10 as follows: funct3 000 gives ADD (funct7_5=0) or SUB (funct7_5=1); 111 gives AND; 110 gives OR; 010 gives SLT; any other funct3 is illegal.
REQ-014 SHALL decode alu_op 11 the same as alu_op 10, except funct3 000 always gives ADD (funct7_5 ignored).
REQ-015 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-016 SHALL assert in_ready only in IDLE, except as extended by REQ-027.
REQ-017 SHALL, in IDLE with in_valid=1, register the operands and decoded control and move to EXEC.
REQ-018 SHALL, in EXEC, drive alu_inp1/alu_inp2/alu_control from those registers, capture alu_out/alu_zero at the next clk edge, and move to DONE.
REQ-019 SHALL, in DONE, hold out_valid=1 with a stable payload until out_ready=1, then move to IDLE.
REQ-020 SHALL have latency such that a request accepted at edge N gives out_valid=1 after edge N+2.
REQ-021 SHALL, for an illegal decode, register alu_control=ADD with operands forced to 0 and produce out_result=0, out_zero=0, out_illegal=1.
REQ-022 SHALL, outside EXEC, hold alu_inp1, alu_inp2 and alu_control at their last registered values, so no glitching drive reaches the ALU.
REQ-023 SHALL treat a DONE with out_ready=1 and in_valid=1 as a plain transition to IDLE, leaving the request pending, unless REQ-027 applies.
REQ-024 SHALL pass operands unchanged at full 32-bit width; the block performs no arithmetic itself.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, force state=IDLE, in_ready=1 from the following cycle, and out_valid=0.
REQ-026 SHALL, on reset, clear out_result, out_zero, out_illegal, alu_inp1, alu_inp2 and alu_control(=ADD) to 0; reset during EXEC or DONE discards the transaction with no output.

Configuration
REQ-027 SHALL support macro ALU_ISSUE_OVERLAP_EN; when defined, in_ready = IDLE | (DONE & out_ready), and a DONE with out_ready=1 and in_valid=1 accepts the new request and goes directly to EXEC, giving one result per 2 cycles.
REQ-028 SHALL, with ALU_ISSUE_OVERLAP_EN undefined, behave exactly per REQ-016/REQ-023, giving one result per 3 cycles.

Structure
REQ-029 SHALL place the ALU control encodings, alu_op encodings and FSM state encodings in shared package alu_pkg, for use by ALU and pipeline code.
REQ-030 SHALL place decode logic in one combinational sub-module alu_decode (inputs alu_op/funct3/funct7_5; outputs alu_control and illegal), with the FSM and registers in alu_issue_ctrl.

Verification
REQ-031 SHALL cover: R-type funct3=000, funct7_5=1, a=10, b=3 -> alu_control=001 in EXEC; out_result=7, out_zero=0 two edges after accept.
REQ-032 SHALL cover: branch alu_op=01, a=b=0x55 -> SUB; out_result=0, out_zero=1.
REQ-033 SHALL cover: I-type funct3=010, a=2, b=5 -> SLT; out_result=1; then R-type funct3=001 -> out_illegal=1, out_result=0, out_zero=0.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and payload stable, in_ready=0; a new in_valid is not accepted.
REQ-035 SHALL cover: rst pulsed during EXEC -> no out_valid, in_ready=1 afterwards, all outputs 0.
REQ-036 SHALL cover: back-to-back requests with out_ready=1 -> results every 3 cycles without ALU_ISSUE_OVERLAP_EN and every 2 cycles with it, results in order.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared encodings for the ALU, its issue controller and pipeline code:
//   - alu_ctrl_e    : 3-bit control word understood by the combinational ALU
//   - alu_op_e      : 2-bit instruction class produced by the main decoder
//   - issue_state_e : states of the alu_issue_ctrl handshake FSM
//   - F3_*          : funct3 values recognised for R-type / I-type ops
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALU_OP_LDST   = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } issue_state_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Purely combinational translation of instruction class and function fields
// into the ALU control word.
// Ports:
//   alu_op      in  [1:0] instruction class (load/store, branch, R, I)
//   funct3      in  [2:0] instruction funct3 field
//   funct7_5    in        bit 5 of funct7 (selects SUB for R-type 000)
//   alu_control out [2:0] ALU control word (ADD whenever illegal)
//   illegal     out       funct3 not supported for R/I-type
// ---------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Load/store always adds (address calc), branches always subtract
    // (compare via zero flag). R-type and I-type share the funct3 table;
    // only R-type honours funct7_5 to pick SUB, since I-type has no SUBI.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALU_OP_LDST:   alu_control = ALU_ADD;
            ALU_OP_BRANCH: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    F3_ADD_SUB: alu_control = (alu_op == ALU_OP_RTYPE && funct7_5)
                                              ? ALU_SUB : ALU_ADD;
                    F3_AND:     alu_control = ALU_AND;
                    F3_OR:      alu_control = ALU_OR;
                    F3_SLT:     alu_control = ALU_SLT;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issues one request at a time to an external combinational ALU and returns
// the captured result through a valid/ready handshake.
// FSM: IDLE (accept) -> EXEC (ALU evaluates, result captured) -> DONE (hold
// result until out_ready).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid / in_ready            request handshake
//   alu_op, funct3, funct7_5       instruction class and function fields
//   opnd_a, opnd_b                 32-bit operands (immediate already muxed)
//   alu_inp1, alu_inp2, alu_control registered drive to the ALU
//   alu_out, alu_zero              ALU response
//   out_valid / out_ready          result handshake
//   out_result, out_zero, out_illegal result payload
// Configuration macro ALU_ISSUE_OVERLAP_EN: when defined, a new request may be
// accepted in DONE in the same cycle the result is taken, so the FSM goes
// straight back to EXEC (one result per 2 cycles instead of 3).
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] opnd_a,
    input  logic [31:0] opnd_b,
    output logic [31:0] alu_inp1,
    output logic [31:0] alu_inp2,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_illegal
);

    issue_state_e state;
    logic         illegal_q;
    logic [2:0]   dec_control;
    logic         dec_illegal;
    logic         accept;

    alu_decode u_decode (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

`ifdef ALU_ISSUE_OVERLAP_EN
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
`else
    assign in_ready = (state == ST_IDLE);
`endif

    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // ALU drive registers only change on acceptance, so the ALU inputs are
    // stable through EXEC and simply hold their last value elsewhere.
    // An illegal op is issued as ADD 0+0 and its result is overridden on
    // capture, because the ALU would otherwise report zero=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            illegal_q   <= 1'b0;
            alu_inp1    <= '0;
            alu_inp2    <= '0;
            alu_control <= ALU_ADD;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (accept) begin
                alu_inp1    <= dec_illegal ? 32'd0 : opnd_a;
                alu_inp2    <= dec_illegal ? 32'd0 : opnd_b;
                alu_control <= dec_control;
                illegal_q   <= dec_illegal;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_result  <= illegal_q ? 32'd0 : alu_out;
                    out_zero    <= illegal_q ? 1'b0 : alu_zero;
                    out_illegal <= illegal_q;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    // accept can only be high here in the overlap build
                    if (out_ready) begin
                        state <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU
// attached to the issue interface. Expected results are hand-computed.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_OVERLAP_EN
    localparam int RESULT_PERIOD = 2;
`else
    localparam int RESULT_PERIOD = 3;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [2:0]  alu_control;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .opnd_a      (opnd_a),
        .opnd_b      (opnd_b),
        .alu_inp1    (alu_inp1),
        .alu_inp2    (alu_inp2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU the controller drives
    always_comb begin
        alu_out = 32'd0;
        case (alu_control)
            3'b000: alu_out = alu_inp1 + alu_inp2;
            3'b001: alu_out = alu_inp1 - alu_inp2;
            3'b010: alu_out = alu_inp1 & alu_inp2;
            3'b011: alu_out = alu_inp1 | alu_inp2;
            3'b101: alu_out = {31'd0, ($signed(alu_inp1) < $signed(alu_inp2))};
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction: accept, EXEC drive, DONE payload, drain
    task automatic apply_stimulus(input string tag,
                                  input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] exp_ctrl,
                                  input logic [31:0] exp_a, input logic [31:0] exp_b,
                                  input logic [31:0] exp_res,
                                  input logic exp_zero, input logic exp_ill);
        check_output({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
        opnd_a   = a;
        opnd_b   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_output({tag, ".exec_ctrl"}, {29'd0, alu_control}, {29'd0, exp_ctrl});
        check_output({tag, ".exec_inp1"}, alu_inp1, exp_a);
        check_output({tag, ".exec_inp2"}, alu_inp2, exp_b);
        check_output({tag, ".exec_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        check_output({tag, ".done_valid"}, {31'd0, out_valid}, 32'd1);
        check_output({tag, ".result"}, out_result, exp_res);
        check_output({tag, ".zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
        check_output({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
        check_output({tag, ".held_inp1"}, alu_inp1, exp_a);
        check_output({tag, ".held_ctrl"}, {29'd0, alu_control}, {29'd0, exp_ctrl});
    endtask

    initial begin
        int exp_b2b [4];
        int req_idx;
        int res_idx;
        int last_cyc;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        opnd_a    = 32'd0;
        opnd_b    = 32'd0;
        step();
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst.out_result", out_result, 32'd0);
        check_output("rst.alu_ctrl", {29'd0, alu_control}, 32'd0);
        check_output("rst.alu_inp1", alu_inp1, 32'd0);

        $display("[TB] R-type SUB 10-3, then DONE stall");
        apply_stimulus("rsub", 2'b10, 3'b000, 1'b1, 32'd10, 32'd3,
                       3'b001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);

        // DONE held with out_ready low; a competing request must not enter
        alu_op   = 2'b10; funct3 = 3'b111; funct7_5 = 1'b0;
        opnd_a   = 32'h0000_00F0; opnd_b = 32'h0000_0F0F;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_output("stall.valid0", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b1;
        opnd_a   = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            step();
            check_output("stall.valid", {31'd0, out_valid}, 32'd1);
            check_output("stall.result", out_result, 32'h0000_00F0 & 32'h0000_0F0F);
            check_output("stall.in_ready", {31'd0, in_ready}, 32'd0);
            check_output("stall.inp1", alu_inp1, 32'h0000_00F0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_output("stall.drained", {31'd0, out_valid}, 32'd0);
        check_output("stall.idle_ready", {31'd0, in_ready}, 32'd1);

        $display("[TB] branch, I-type, illegal, logic ops");
        apply_stimulus("branch", 2'b01, 3'b111, 1'b1, 32'h55, 32'h55,
                       3'b001, 32'h55, 32'h55, 32'd0, 1'b1, 1'b0);
        apply_stimulus("islt", 2'b11, 3'b010, 1'b0, 32'd2, 32'd5,
                       3'b101, 32'd2, 32'd5, 32'd1, 1'b0, 1'b0);
        apply_stimulus("illegal", 2'b10, 3'b001, 1'b0, 32'd9, 32'd4,
                       3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        apply_stimulus("iadd_f7", 2'b11, 3'b000, 1'b1, 32'd5, 32'd6,
                       3'b000, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
        apply_stimulus("ldst_wrap", 2'b00, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd1,
                       3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        apply_stimulus("slt_neg", 2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,
                       3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        apply_stimulus("rand", 2'b10, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00,
                       3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        apply_stimulus("ror", 2'b10, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_FF00,
                       3'b011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);

        $display("[TB] reset during EXEC");
        alu_op   = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0;
        opnd_a   = 32'd100; opnd_b = 32'd23;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check_output("rstx.out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rstx.in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rstx.out_result", out_result, 32'd0);
        check_output("rstx.out_zero", {31'd0, out_zero}, 32'd0);
        check_output("rstx.out_illegal", {31'd0, out_illegal}, 32'd0);
        check_output("rstx.alu_inp1", alu_inp1, 32'd0);
        check_output("rstx.alu_inp2", alu_inp2, 32'd0);
        check_output("rstx.alu_ctrl", {29'd0, alu_control}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_output("rstx.no_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] back-to-back requests");
        // Request i: ADD (i*10) + (i+1)
        exp_b2b[0] = 1;
        exp_b2b[1] = 12;
        exp_b2b[2] = 23;
        exp_b2b[3] = 34;
        req_idx   = 0;
        res_idx   = 0;
        last_cyc  = -1;
        out_ready = 1'b1;
        alu_op    = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0;
        opnd_a    = 32'd0; opnd_b = 32'd1;
        in_valid  = 1'b1;
        for (int k = 0; k < 30 && res_idx < 4; k++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                req_idx++;
                if (req_idx < 4) begin
                    opnd_a = 32'(req_idx * 10);
                    opnd_b = 32'(req_idx + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check_output("b2b.result", out_result, 32'(exp_b2b[res_idx]));
                if (last_cyc >= 0) begin
                    check_output("b2b.period", 32'(cyc - last_cyc), 32'(RESULT_PERIOD));
                end
                last_cyc = cyc;
                res_idx++;
            end
        end
        check_output("b2b.count", 32'(res_idx), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
